dds_sine_gen: RTL
=================

Name: dds_sine_gen

Overview:
- Direct digital synthesis source for the AN9767 dual 14-bit DAC path.
- Replaces the free-running ROM address counter with:
  - a programmable 32-bit phase accumulator,
  - a quarter-wave sine lookup,
  - amplitude scaling.
- Drives one channel's 14-bit offset-binary data bus at the DAC clock (125 MHz). The DAC clock and write-strobe pins are driven outside this block.

Parameters:
- PHASE_W, 32: phase accumulator width.
- IDX_W, 10: full-wave phase index width; the quarter table holds 2^(IDX_W-2) = 256 entries.
- DAC_W, 14: output sample width; table magnitude width is DAC_W-1 = 13.
- AMP_W, 11: amplitude word width; 1024 = unity gain.

Ports:
- clk, in, 1: DAC-domain clock, 125 MHz; all logic on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: run enable.
- ftw, in, PHASE_W: frequency tuning word.
- ftw_wr, in, 1: one-cycle strobe that latches ftw.
- phase_clr, in, 1: one-cycle strobe that zeroes the accumulator.
- amp, in, AMP_W: amplitude, unsigned.
- dac_data, out, DAC_W: offset-binary sample to the DAC.
- dac_valid, out, 1: dac_data carries a synthesized sample.

Behaviour:
- Reset values:
  - acc = 0, ftw_reg = 0.
  - All pipeline registers = 0.
  - dac_data = 8192 (midscale, 0 V).
  - dac_valid = 0.
- Tuning word:
  - ftw_reg <= ftw on ftw_wr.
  - The accumulator first uses the new value on the following cycle.
  - No phase discontinuity on a tuning update.
- Accumulator:
  - phase_clr: acc <= 0 (highest priority; takes effect even when en = 0).
  - Else if en: acc <= acc + ftw_reg, modulo 2^PHASE_W (natural wrap).
  - Else: acc holds.
  - ftw_wr and phase_clr in the same cycle: both take effect.
- Index and quadrant mapping:
  - idx = acc[PHASE_W-1 -: IDX_W], q = idx[9:8], off = idx[7:0].
  - Table address = q[0] ? ~off : off.
  - sign = q[1].
- Table contents:
  - Entry k = round(8191 * sin(2*pi*(k+0.5)/1024)), k = 0..255; range 25..8191.
  - The half-sample offset makes the mirrored quadrants exact and means no sample is ever 0.
- Pipeline, one register per stage:
  - S1: address and sign registered.
  - S2: synchronous table read.
  - S3: signed value = sign ? -mag : mag (14-bit two's complement, ±8191).
  - S4: product = value * min(amp, 1024); result = product >>> 10 (arithmetic shift, floor).
  - S5: dac_data = result + 8192, truncated to 14 bits.
  - Latency is 5 cycles from an accumulator value to dac_data.
  - Output range is 1..16383; the code never wraps.
- Amplitude:
  - amp > 1024 saturates to 1024.
  - amp = 0 gives a constant 8192.
  - amp is sampled at S4, so a change reaches the output 2 cycles later.
- Valid:
  - A 5-deep shift register carries en.
  - dac_valid = its last stage.
  - While the last stage is 0, dac_data is forced to 8192.
  - en rise to dac_valid rise is 5 cycles; en fall to dac_valid fall is 5 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately, so the output steps to midscale.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every en cycle.
  - Its value is added to acc[PHASE_W-IDX_W-1:0] before index extraction, to spread phase-truncation spurs.
  - The dither sum carries into idx.
  - The accumulator itself is unaffected.
  - Latency is unchanged.
- Undefined: no LFSR, and index extraction is direct truncation as described above.

Decomposition:
- Shared package dds_pkg:
  - Constants DDS_MIDSCALE = 14'd8192, DDS_UNITY_AMP = 11'd1024, LUT depth 256.
  - A typedef for quadrant-decoded {sign, addr}.
- Sub-module sine_qlut:
  - 256x13 synchronous ROM with a registered output, inferred from a case or initial table.
  - Separate so it can be swapped for a BRAM instance.

Test Plan:
- Reset, then en=1, ftw=2^22, amp=1024:
  - dac_valid rises 5 cycles after en.
  - First sample 8217 (8192+25).
  - Peak 16383 at idx 255/256, trough 1 at idx 767/768.
  - Period exactly 1024 samples (122.07 kHz).
- ftw=2^29, amp=1024:
  - 8-sample period (15.625 MHz).
  - Sample for idx 128 = 14002 ±1.
  - Sequence is symmetric about 8192.
- amp=512 with ftw=2^22:
  - Peak 12287, trough 4096 (floor rounding).
  - amp=2047 produces an output identical to amp=1024.
  - amp=0 produces a constant 8192.
- phase_clr mid-run with ftw_wr=1 and ftw=2^23 in the same cycle:
  - Accumulator restarts at 0.
  - 5 cycles later, output 8217 followed by a 2-index step sequence.
- en dropped mid-run:
  - dac_valid falls 5 cycles later and dac_data = 8192.
  - On re-enable, the waveform resumes from the held phase.
  - Then assert rst_n=0 asynchronously between clock edges: dac_data = 8192 and dac_valid = 0 without waiting for a clock edge.
- With DDS_PHASE_DITHER_EN and ftw=2^22+2^20:
  - Spectrum spur level is lower than the undithered build.
  - Peak output ≤ 16383 and trough ≥ 1.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, quadrant-decode type and quarter-sine table generator for the DDS.
package dds_pkg;
  localparam int LUT_DEPTH = 256;
  localparam int LUT_AW = 8;
  localparam int LUT_MW = 13;
  localparam logic [13:0] DDS_MIDSCALE = 14'd8192;
  localparam logic [10:0] DDS_UNITY_AMP = 11'd1024;
  typedef struct packed {
    logic sign;
    logic [LUT_AW-1:0] addr;
  } qdec_t;
  function automatic qdec_t quad_decode(input logic [LUT_AW+1:0] idx);
    return '{sign: idx[LUT_AW+1], addr: idx[LUT_AW] ? ~idx[LUT_AW-1:0] : idx[LUT_AW-1:0]};
  endfunction
  // Half-sample offset keeps the mirrored quadrants exact and no entry is ever 0.
  function automatic logic [LUT_MW-1:0] qsin(input int k);
    return LUT_MW'($rtoi(8191.0 * $sin(2.0 * 3.141592653589793 * (real'(k) + 0.5) / 1024.0) + 0.5));
  endfunction
endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: 256x13 quarter-wave sine ROM with registered output (swappable for a BRAM).
module sine_qlut
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_MW-1:0] mag
);
  logic [LUT_MW-1:0] rom [LUT_DEPTH];
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    assign rom[k] = qsin(k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mag <= '0;
    else mag <= rom[addr];
endmodule

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: phase-accumulator DDS with quarter-wave sine lookup and amplitude scaling for a 14-bit DAC.
// Optional phase dither before index truncation: define DDS_PHASE_DITHER_EN.
module dds_sine_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int IDX_W = 10,
  parameter int DAC_W = 14,
  parameter int AMP_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_wr,
  input  logic               phase_clr,
  input  logic [AMP_W-1:0]   amp,
  output logic [DAC_W-1:0]   dac_data,
  output logic               dac_valid
);
  localparam int SHIFT = $clog2(DDS_UNITY_AMP);
  logic [PHASE_W-1:0] acc, ftw_reg, phase;
  qdec_t s1;
  logic s2_sign;
  logic [LUT_MW-1:0] mag;
  logic signed [DAC_W-1:0] s3_val, s4_res;
  logic [AMP_W-1:0] amp_sat;
  logic signed [DAC_W+AMP_W:0] prod;
  logic [4:0] vld;
`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // Dither sits below the index bits; the carry is allowed to reach idx.
  assign phase = acc + PHASE_W'(lfsr);
`else
  assign phase = acc;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ftw_reg <= '0;
    end else begin
      if (ftw_wr) ftw_reg <= ftw;
      if (phase_clr) acc <= '0;
      else if (en) acc <= acc + ftw_reg;
    end
  sine_qlut u_lut (.clk(clk), .rst_n(rst_n), .addr(s1.addr), .mag(mag));
  assign amp_sat = amp > DDS_UNITY_AMP ? DDS_UNITY_AMP : amp;
  assign prod = s3_val * $signed({1'b0, amp_sat});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2_sign <= 1'b0;
      s3_val <= '0;
      s4_res <= '0;
      vld <= '0;
      dac_data <= DDS_MIDSCALE;
    end else begin
      s1 <= quad_decode(phase[PHASE_W-1 -: IDX_W]);
      s2_sign <= s1.sign;
      s3_val <= s2_sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      s4_res <= DAC_W'(prod >>> SHIFT);
      vld <= {vld[3:0], en};
      dac_data <= vld[3] ? DAC_W'($unsigned(s4_res) + DDS_MIDSCALE) : DDS_MIDSCALE;
    end
  assign dac_valid = vld[4];
endmodule
